// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, header field positions and FSM encoding for the SPI command sequencer.
package spi_cmd_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned HDR_ADDR_W = 12;
  localparam int unsigned HDR_LEN_W  = 16;
  localparam int unsigned FCNT_W     = 16;

  localparam int unsigned HDR_OP_MSB   = 31;
  localparam int unsigned HDR_OP_LSB   = 28;
  localparam int unsigned HDR_ADDR_MSB = 27;
  localparam int unsigned HDR_ADDR_LSB = 16;
  localparam int unsigned HDR_LEN_MSB  = 15;
  localparam int unsigned HDR_LEN_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP       = 4'h0;
  localparam logic [OP_W-1:0] OP_REG_WR    = 4'h1;
  localparam logic [OP_W-1:0] OP_MEM_BURST = 4'h2;
  localparam logic [OP_W-1:0] OP_TRIG      = 4'h3;

  typedef enum logic {
    S_HDR  = 1'b0,
    S_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/cmd_watchdog.sv
// Idle-cycle counter that fires a single-cycle expire when TIMEOUT-1 is reached while enabled.
module cmd_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic synth_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = en && (cnt_q == CNT_LAST);

  // Count enabled cycles; restart on clear or after firing.
  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || expire_c) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Drains command frames from the SPI FIFO and dispatches register, memory and trigger actions.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned REG_AW  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                synth_clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic                fifo_valid,
  input  logic [WORD_W-1:0]   fifo_data,
  output logic                fifo_rd,
  input  logic                spi_busy,
  output logic                reg_we,
  output logic [REG_AW-1:0]   reg_addr,
  output logic [WORD_W-1:0]   reg_wdata,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                trig,
  output logic                err_badop,
  output logic                err_timeout,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic                in_frame
);

  state_t                 state_q, state_d;
  logic [HDR_LEN_W-1:0]   rem_q, rem_d;
  logic                   is_mem_q, is_mem_d;
  logic [MEM_AW-1:0]      waddr_q, waddr_d;
  logic [REG_AW-1:0]      raddr_q, raddr_d;
  logic                   rd_pend_q, rd_pend_d;

  logic                   reg_we_d, mem_we_d, trig_d, err_badop_d, err_timeout_d, in_frame_d;
  logic [REG_AW-1:0]      reg_addr_d;
  logic [WORD_W-1:0]      reg_wdata_d, mem_wdata_d;
  logic [MEM_AW-1:0]      mem_addr_d;
  logic [FCNT_W-1:0]      frame_cnt_d;

  logic [OP_W-1:0]        hdr_op_c;
  logic [HDR_ADDR_W-1:0]  hdr_addr_c;
  logic [HDR_LEN_W-1:0]   hdr_len_c;
  logic                   stall_c, decode_c, frame_done_c;
  logic                   wd_clr_c, wd_en_c, wd_expire_c;
  logic                   unused_spi_busy;

  // CS activity is status only; sequencing is driven purely by FIFO contents.
  assign unused_spi_busy = spi_busy;

  assign hdr_op_c   = fifo_data[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_addr_c = fifo_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_len_c  = fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];

  assign stall_c  = mem_we && !mem_ready;
  assign decode_c = (state_q == S_HDR) && fifo_valid;

  // One read in flight at most; never read into a stalled memory write.
  assign fifo_rd = rst_n && !fifo_empty && !rd_pend_q && !stall_c && !decode_c;

  assign wd_en_c  = (state_q == S_DATA) && !fifo_valid && !stall_c;
  assign wd_clr_c = (state_q != S_DATA) || fifo_valid || stall_c;

  cmd_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .synth_clk (synth_clk),
    .rst_n     (rst_n),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expire_c  (wd_expire_c)
  );

  // Next-state, frame parsing and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    is_mem_d      = is_mem_q;
    waddr_d       = waddr_q;
    raddr_d       = raddr_q;
    rd_pend_d     = rd_pend_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr;
    reg_wdata_d   = reg_wdata;
    mem_we_d      = stall_c;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    trig_d        = 1'b0;
    err_badop_d   = 1'b0;
    err_timeout_d = 1'b0;
    frame_done_c  = 1'b0;

    if (fifo_valid) rd_pend_d = 1'b0;
    if (fifo_rd)    rd_pend_d = 1'b1;

    case (state_q)
      S_HDR: begin
        if (fifo_valid) begin
          case (hdr_op_c)
            OP_NOP: frame_done_c = 1'b1;
            OP_REG_WR: begin
              state_d  = S_DATA;
              rem_d    = HDR_LEN_W'(1);
              is_mem_d = 1'b0;
              raddr_d  = REG_AW'(hdr_addr_c);
            end
            OP_MEM_BURST: begin
              if (hdr_len_c == '0) begin
                frame_done_c = 1'b1;
              end else begin
                state_d  = S_DATA;
                rem_d    = hdr_len_c;
                is_mem_d = 1'b1;
                waddr_d  = MEM_AW'(hdr_addr_c);
              end
            end
            OP_TRIG: begin
              trig_d       = 1'b1;
              frame_done_c = 1'b1;
            end
            default: begin
              err_badop_d  = 1'b1;
              frame_done_c = 1'b1;
            end
          endcase
        end
      end
      S_DATA: begin
        // A payload word arriving on the expiry cycle takes priority over the abort.
        if (fifo_valid) begin
          if (is_mem_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr_q;
            mem_wdata_d = fifo_data;
            waddr_d     = waddr_q + MEM_AW'(1);
          end else begin
            reg_we_d    = 1'b1;
            reg_addr_d  = raddr_q;
            reg_wdata_d = fifo_data;
          end
          rem_d = rem_q - HDR_LEN_W'(1);
          if (rem_q == HDR_LEN_W'(1)) begin
            state_d      = S_HDR;
            frame_done_c = 1'b1;
          end
        end else if (wd_expire_c) begin
          err_timeout_d = 1'b1;
          state_d       = S_HDR;
          rem_d         = '0;
        end
      end
      default: state_d = S_HDR;
    endcase

    frame_cnt_d = frame_done_c ? frame_cnt + FCNT_W'(1) : frame_cnt;
    in_frame_d  = (state_d == S_DATA);
  end

  // State and registered output stage.
  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      rem_q       <= '0;
      is_mem_q    <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      rd_pend_q   <= 1'b0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      trig        <= 1'b0;
      err_badop   <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
      in_frame    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      is_mem_q    <= is_mem_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      rd_pend_q   <= rd_pend_d;
      reg_we      <= reg_we_d;
      reg_addr    <= reg_addr_d;
      reg_wdata   <= reg_wdata_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      trig        <= trig_d;
      err_badop   <= err_badop_d;
      err_timeout <= err_timeout_d;
      frame_cnt   <= frame_cnt_d;
      in_frame    <= in_frame_d;
    end
  end

endmodule
